pll_lock_rstgen: RTL and testbench

//  Consumes the PLL output clock and LOCK flag; produces the core reset and a qualified lock status.

---
 rtl/pll_lock_rstgen.sv | 145 ++++++++++++++
 tb/tb_pll_lock_rstgen.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pll_lock_rstgen.sv
// PLL lock qualifier and core reset generator: synchronizes LOCK, waits for it to be stable,
// holds the core in reset for a short time after lock, and pulls reset again on a sustained lock loss.
module pll_lock_rstgen #(
    parameter int SYNC_STAGES     = 2,
    parameter int LOCK_CYCLES     = 1024,
    parameter int RST_HOLD_CYCLES = 16,
    parameter int GLITCH_CYCLES   = 4
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       lock_i,
    output logic       rstn_o,
    output logic       locked_o,
    output logic [7:0] lost_cnt_o,
    output logic [2:0] state_o
);

    localparam int CNT_MAX_LH = (LOCK_CYCLES > RST_HOLD_CYCLES) ? LOCK_CYCLES : RST_HOLD_CYCLES;
    localparam int CNT_MAX    = (CNT_MAX_LH > GLITCH_CYCLES) ? CNT_MAX_LH : GLITCH_CYCLES;
    localparam int CNT_W      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GLITCH_LAST = CNT_W'(GLITCH_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_WAIT   = 3'd0,
        ST_STABLE = 3'd1,
        ST_HOLD   = 3'd2,
        ST_RUN    = 3'd3,
        ST_LOST   = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   lock_s;
    state_t                 state_q;
    state_t                 state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   rstn_q;
    logic                   rstn_d;
    logic                   locked_q;
    logic                   locked_d;
    logic [7:0]             lost_cnt_q;
    logic [7:0]             lost_cnt_d;

    // lock_i is asynchronous to clk_i; only the last stage of this chain is ever used.
    assign sync_d[0] = lock_i;
    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            assign sync_d[gi] = sync_q[gi-1];
        end
    endgenerate
    assign lock_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_WAIT: begin
                cnt_d = '0;
                if (lock_s) begin
                    state_d = ST_STABLE;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                // A drop outranks reaching the hold terminal count in the same cycle.
                if (!lock_s) begin
                    state_d = ST_LOST;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (lock_s) begin
                    cnt_d = '0;
                end else if (cnt_q == GLITCH_LAST) begin
                    state_d = ST_LOST;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_LOST: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decode the next state so they move on the same edge as state_q.
    always_comb begin
        rstn_d     = (state_d == ST_RUN);
        locked_d   = (state_d == ST_HOLD) || (state_d == ST_RUN);
        lost_cnt_d = lost_cnt_q;
        if ((state_d == ST_LOST) && (state_q != ST_LOST) && (lost_cnt_q != 8'hFF)) begin
            lost_cnt_d = lost_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q     <= '0;
            state_q    <= ST_WAIT;
            cnt_q      <= '0;
            rstn_q     <= 1'b0;
            locked_q   <= 1'b0;
            lost_cnt_q <= 8'd0;
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rstn_q     <= rstn_d;
            locked_q   <= locked_d;
            lost_cnt_q <= lost_cnt_d;
        end
    end

    assign rstn_o     = rstn_q;
    assign locked_o   = locked_q;
    assign lost_cnt_o = lost_cnt_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_pll_lock_rstgen.sv
// Directed bench for pll_lock_rstgen with short qualification times (2/8/4/3).
module tb_pll_lock_rstgen;

    logic       clk_i;
    logic       rstn_i;
    logic       lock_i;
    logic       rstn_o;
    logic       locked_o;
    logic [7:0] lost_cnt_o;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        lock;
        int          cycles;
        logic [2:0]  st;
        logic        rstn;
        logic        locked;
        logic [7:0]  lost;
    } vec_t;

    vec_t vecs[$];

    pll_lock_rstgen #(
        .SYNC_STAGES    (2),
        .LOCK_CYCLES    (8),
        .RST_HOLD_CYCLES(4),
        .GLITCH_CYCLES  (3)
    ) dut (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .lock_i    (lock_i),
        .rstn_o    (rstn_o),
        .locked_o  (locked_o),
        .lost_cnt_o(lost_cnt_o),
        .state_o   (state_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [2:0] st, input logic rstn,
                         input logic locked, input logic [7:0] lost);
        n_checks++;
        if (state_o !== st || rstn_o !== rstn || locked_o !== locked || lost_cnt_o !== lost) begin
            n_fail++;
            $display("FAIL %s: got state=%0d rstn=%b locked=%b lost=%0d, expected state=%0d rstn=%b locked=%b lost=%0d",
                     name, state_o, rstn_o, locked_o, lost_cnt_o, st, rstn, locked, lost);
        end
    endtask

    task automatic add(input logic lock, input int cycles, input logic [2:0] st,
                       input logic rstn, input logic locked, input logic [7:0] lost);
        vec_t v;
        v.lock = lock; v.cycles = cycles; v.st = st;
        v.rstn = rstn; v.locked = locked; v.lost = lost;
        vecs.push_back(v);
    endtask

    // lock_i is already 1 and was first sampled on the first edge after reset release.
    task automatic relock_check(input string tag);
        step(9);
        check({tag, "_edge9"}, 3'd1, 1'b0, 1'b0, 8'd0);
        step(1);
        check({tag, "_edge10_locked"}, 3'd2, 1'b0, 1'b1, 8'd0);
        step(3);
        check({tag, "_edge13_hold"}, 3'd2, 1'b0, 1'b1, 8'd0);
        step(1);
        check({tag, "_edge14_run"}, 3'd3, 1'b1, 1'b1, 8'd0);
    endtask

    initial begin
        logic [7:0] exp_lost;

        // lock, edges, state, rstn, locked, lost
        add(1'b0, 2, 3'd0, 1'b0, 1'b0, 8'd0);   // idle after release
        add(1'b1, 2, 3'd0, 1'b0, 1'b0, 8'd0);   // lock_s just arrived
        add(1'b1, 1, 3'd1, 1'b0, 1'b0, 8'd0);   // WAIT->STABLE
        add(1'b1, 6, 3'd1, 1'b0, 1'b0, 8'd0);   // edge 9, cnt=7
        add(1'b1, 1, 3'd2, 1'b0, 1'b1, 8'd0);   // edge 10: locked
        add(1'b1, 3, 3'd2, 1'b0, 1'b1, 8'd0);   // edge 13: still in hold
        add(1'b1, 1, 3'd3, 1'b1, 1'b1, 8'd0);   // edge 14: run
        add(1'b0, 2, 3'd3, 1'b1, 1'b1, 8'd0);   // 2-cycle dropout
        add(1'b1, 4, 3'd3, 1'b1, 1'b1, 8'd0);   // ignored
        add(1'b0, 4, 3'd3, 1'b1, 1'b1, 8'd0);   // 3-cycle dropout, cnt=2
        add(1'b0, 1, 3'd4, 1'b0, 1'b0, 8'd1);   // LOST
        add(1'b0, 1, 3'd0, 1'b0, 1'b0, 8'd1);   // WAIT
        add(1'b0, 2, 3'd0, 1'b0, 1'b0, 8'd1);
        add(1'b1, 5, 3'd1, 1'b0, 1'b0, 8'd1);   // STABLE cnt=3
        add(1'b0, 1, 3'd1, 1'b0, 1'b0, 8'd1);   // cnt=4, low sample in flight
        add(1'b1, 1, 3'd1, 1'b0, 1'b0, 8'd1);   // cnt=5
        add(1'b1, 1, 3'd0, 1'b0, 1'b0, 8'd1);   // drop seen: back to WAIT
        add(1'b1, 1, 3'd1, 1'b0, 1'b0, 8'd1);   // requalification starts
        add(1'b1, 6, 3'd1, 1'b0, 1'b0, 8'd1);   // 7th edge, not yet locked
        add(1'b1, 1, 3'd2, 1'b0, 1'b1, 8'd1);   // 8th edge: locked
        add(1'b1, 4, 3'd3, 1'b1, 1'b1, 8'd1);
        add(1'b0, 4, 3'd3, 1'b1, 1'b1, 8'd1);   // second loss
        add(1'b0, 1, 3'd4, 1'b0, 1'b0, 8'd2);
        add(1'b0, 1, 3'd0, 1'b0, 1'b0, 8'd2);
        add(1'b1, 10, 3'd2, 1'b0, 1'b1, 8'd2);  // into HOLD
        add(1'b1, 1, 3'd2, 1'b0, 1'b1, 8'd2);
        add(1'b0, 2, 3'd2, 1'b0, 1'b1, 8'd2);   // hold cnt at terminal value
        add(1'b0, 1, 3'd4, 1'b0, 1'b0, 8'd3);   // drop beats hold terminal
        add(1'b0, 1, 3'd0, 1'b0, 1'b0, 8'd3);

        // Asynchronous reset with the clock running and lock_i high.
        rstn_i = 1'b1;
        lock_i = 1'b1;
        #12;
        rstn_i = 1'b0;
        #1;
        check("async_reset_no_edge", 3'd0, 1'b0, 1'b0, 8'd0);
        step(2);
        check("reset_held_clocked", 3'd0, 1'b0, 1'b0, 8'd0);
        lock_i = 1'b0;
        step(1);
        rstn_i = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            lock_i = vecs[i].lock;
            step(vecs[i].cycles);
            check($sformatf("vec[%0d]", i), vecs[i].st, vecs[i].rstn, vecs[i].locked, vecs[i].lost);
            $display("vec[%0d] lock=%b edges=%0d -> state=%0d rstn=%b locked=%b lost=%0d",
                     i, vecs[i].lock, vecs[i].cycles, state_o, rstn_o, locked_o, lost_cnt_o);
        end

        // 256 lose/relock rounds through HOLD; counter must saturate.
        exp_lost = 8'd3;
        for (int i = 0; i < 256; i++) begin
            lock_i = 1'b1;
            step(10);
            check($sformatf("sat_hold[%0d]", i), 3'd2, 1'b0, 1'b1, exp_lost);
            lock_i = 1'b0;
            step(3);
            if (exp_lost != 8'd255) exp_lost = exp_lost + 8'd1;
            check($sformatf("sat_lost[%0d]", i), 3'd4, 1'b0, 1'b0, exp_lost);
            step(1);
        end
        check("sat_final_255", 3'd0, 1'b0, 1'b0, 8'd255);
        $display("saturation rounds done, lost_cnt_o=%0d", lost_cnt_o);

        // Reset in the middle of HOLD.
        lock_i = 1'b1;
        step(11);
        check("pre_reset_hold", 3'd2, 1'b0, 1'b1, 8'd255);
        #3;
        rstn_i = 1'b0;
        #1;
        check("reset_mid_hold", 3'd0, 1'b0, 1'b0, 8'd0);
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        relock_check("relock1");

        // Reset in the middle of RUN.
        step(2);
        check("pre_reset_run", 3'd3, 1'b1, 1'b1, 8'd0);
        #4;
        rstn_i = 1'b0;
        #1;
        check("reset_mid_run", 3'd0, 1'b0, 1'b0, 8'd0);
        step(2);
        check("reset_mid_run_held", 3'd0, 1'b0, 1'b0, 8'd0);
        rstn_i = 1'b1;
        relock_check("relock2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
